// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer, the instruction ROM and the decode/execute stage.
// The sequencer uses the master modport. The ROM and downstream side use the slave modport.
interface fetch_sequencer_if;
   logic        run;
   logic [7:0]  rom_addr;
   logic [31:0] rom_data;
   logic [31:0] instr;
   logic [7:0]  instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic [7:0]  pc;
   logic        halted;

   modport master (
      input  run,
      input  rom_data,
      input  instr_ready,
      input  redirect_valid,
      input  redirect_pc,
      output rom_addr,
      output instr,
      output instr_pc,
      output instr_valid,
      output pc,
      output halted
   );

   modport slave (
      output run,
      output rom_data,
      output instr_ready,
      output redirect_valid,
      output redirect_pc,
      input  rom_addr,
      input  instr,
      input  instr_pc,
      input  instr_valid,
      input  pc,
      input  halted
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller. It owns the PC, waits out the ROM read latency and presents words over valid/ready.
// Branch redirects take priority over everything. An accepted all-zero word parks the FSM in HALT.
module fetch_sequencer #(
   parameter logic [7:0]  RESET_PC     = 8'd4,
   parameter int unsigned ROM_LATENCY  = 2,
   parameter bit          HALT_ON_ZERO = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   fetch_sequencer_if.master bus
);

   localparam int unsigned          CNT_W    = $clog2(ROM_LATENCY + 1);
   localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(ROM_LATENCY);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD,
      HALT
   } FetchState;

   FetchState        r_state;
   logic [7:0]       r_pc;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_instr;
   logic [7:0]       r_instrPc;
   logic             r_instrValid;

   FetchState        w_stateNext;
   logic [7:0]       w_pcNext;
   logic [CNT_W-1:0] w_cntNext;
   logic [31:0]      w_instrNext;
   logic [7:0]       w_instrPcNext;
   logic             w_instrValidNext;
   logic             w_accept;
   logic             w_zeroHit;

   assign w_accept  = r_instrValid & bus.instr_ready;
   assign w_zeroHit = HALT_ON_ZERO && (r_instr == 32'h0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_pc         <= RESET_PC;
         r_cnt        <= '0;
         r_instr      <= 32'h0;
         r_instrPc    <= 8'h0;
         r_instrValid <= 1'b0;
      end else begin
         r_state      <= w_stateNext;
         r_pc         <= w_pcNext;
         r_cnt        <= w_cntNext;
         r_instr      <= w_instrNext;
         r_instrPc    <= w_instrPcNext;
         r_instrValid <= w_instrValidNext;
      end
   end

   // A redirect overrides capture, the handshake and the halt decision. A word accepted in the same cycle is simply dropped.
   always_comb begin
      w_stateNext      = r_state;
      w_pcNext         = r_pc;
      w_cntNext        = r_cnt;
      w_instrNext      = r_instr;
      w_instrPcNext    = r_instrPc;
      w_instrValidNext = r_instrValid;

      if (bus.redirect_valid) begin
         w_pcNext         = {bus.redirect_pc[7:2], 2'b00};
         w_instrValidNext = 1'b0;
         if (bus.run || (r_state == HALT)) begin
            w_stateNext = FETCH;
            w_cntNext   = CNT_LOAD;
         end else begin
            w_stateNext = IDLE;
         end
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.run) begin
                  w_stateNext = FETCH;
                  w_cntNext   = CNT_LOAD;
               end
            end

            FETCH: begin
               if (r_cnt != '0) begin
                  w_cntNext = r_cnt - CNT_W'(1);
               end else begin
                  w_instrNext      = bus.rom_data;
                  w_instrPcNext    = r_pc;
                  w_instrValidNext = 1'b1;
                  w_stateNext      = HOLD;
               end
            end

            HOLD: begin
               if (w_accept) begin
                  w_instrValidNext = 1'b0;
                  w_pcNext         = r_pc + 8'd4;
                  if (w_zeroHit) begin
                     w_stateNext = HALT;
                  end else if (bus.run) begin
                     w_stateNext = FETCH;
                     w_cntNext   = CNT_LOAD;
                  end else begin
                     w_stateNext = IDLE;
                  end
               end
            end

            HALT: begin
               w_instrValidNext = 1'b0;
            end

            default: begin
               w_stateNext = IDLE;
            end
         endcase
      end
   end

   assign bus.rom_addr    = r_pc;
   assign bus.pc          = r_pc;
   assign bus.instr       = r_instr;
   assign bus.instr_pc    = r_instrPc;
   assign bus.instr_valid = r_instrValid;
   assign bus.halted      = (r_state == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer. A ROM with a two-edge registered read feeds the design.
// Directed scenarios run first, then a randomized run checked against a transaction-level PC/halt model.
module tb_fetch_sequencer;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   fetch_sequencer_if bus ();

   fetch_sequencer #(
      .RESET_PC    (8'd4),
      .ROM_LATENCY (2),
      .HALT_ON_ZERO(1'b1)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.master)
   );

   logic [7:0]  rom [256];
   logic [31:0] romPipe;

   function automatic logic [31:0] romWord(input logic [7:0] a);
      return {rom[8'(a + 8'd3)], rom[8'(a + 8'd2)], rom[8'(a + 8'd1)], rom[a]};
   endfunction

   // Two-edge read: the address is registered into romPipe, and romPipe into rom_data.
   always @(posedge clk) begin
      romPipe      <= romWord(bus.rom_addr);
      bus.rom_data <= romPipe;
   end

   task automatic load_rom();
      logic [31:0] w;
      for (int a = 0; a < 256; a += 4) begin
         w = $urandom;
         if (w == 32'h0) w = 32'h1;
         rom[a]   = w[7:0];
         rom[a+1] = w[15:8];
         rom[a+2] = w[23:16];
         rom[a+3] = w[31:24];
      end
      rom[4] = 8'h13; rom[5] = 8'h04; rom[6] = 8'hD0; rom[7] = 8'h01;
      for (int a = 8'h60; a < 8'h64; a++) rom[a] = 8'h00;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.instr_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic pulse_redirect(input logic [7:0] tgt);
      bus.redirect_pc    = tgt;
      bus.redirect_valid = 1'b1;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n              = 1'b0;
      bus.run            = 1'b0;
      bus.instr_ready    = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 8'h0;
      repeat (3) @(negedge clk);
      total += 6;
      if (bus.pc !== 8'd4) begin bad++; $display("[TB] FAIL reset_pc got %h want 04", bus.pc); end
      if (bus.rom_addr !== 8'd4) begin bad++; $display("[TB] FAIL reset_rom_addr got %h want 04", bus.rom_addr); end
      if (bus.instr !== 32'h0) begin bad++; $display("[TB] FAIL reset_instr got %h want 0", bus.instr); end
      if (bus.instr_pc !== 8'h0) begin bad++; $display("[TB] FAIL reset_instr_pc got %h want 00", bus.instr_pc); end
      if (bus.instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got %b want 0", bus.instr_valid); end
      if (bus.halted !== 1'b0) begin bad++; $display("[TB] FAIL reset_halted got %b want 0", bus.halted); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_first_fetch();
      int cycles;
      cycles  = 0;
      bus.run = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.instr_valid) begin
            cycles = i;
            break;
         end
      end
      total += 4;
      if (cycles !== 4) begin bad++; $display("[TB] FAIL first_latency got %0d want 4", cycles); end
      if (bus.instr !== 32'h01D00413) begin bad++; $display("[TB] FAIL first_instr got %h want 01d00413", bus.instr); end
      if (bus.instr_pc !== 8'd4) begin bad++; $display("[TB] FAIL first_instr_pc got %h want 04", bus.instr_pc); end
      if (bus.rom_addr !== 8'd4) begin bad++; $display("[TB] FAIL first_rom_addr got %h want 04", bus.rom_addr); end
      bus.instr_ready = 1'b1;
      @(negedge clk);
      bus.instr_ready = 1'b0;
      total += 2;
      if (bus.pc !== 8'd8) begin bad++; $display("[TB] FAIL first_pc_adv got %h want 08", bus.pc); end
      if (bus.instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL first_valid_drop got %b want 0", bus.instr_valid); end
   endtask

   task automatic test_backpressure();
      bit ok;
      wait_valid(ok);
      total += 3;
      if (!ok) begin bad++; $display("[TB] FAIL bp_wait got valid=0 want 1"); end
      if (bus.instr_pc !== 8'd8) begin bad++; $display("[TB] FAIL bp_instr_pc got %h want 08", bus.instr_pc); end
      if (bus.instr !== romWord(8'd8)) begin bad++; $display("[TB] FAIL bp_instr got %h want %h", bus.instr, romWord(8'd8)); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total += 3;
         if (bus.instr_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_hold_valid got %b want 1", bus.instr_valid); end
         if (bus.instr !== romWord(8'd8)) begin bad++; $display("[TB] FAIL bp_hold_instr got %h want %h", bus.instr, romWord(8'd8)); end
         if (bus.instr_pc !== 8'd8) begin bad++; $display("[TB] FAIL bp_hold_pc got %h want 08", bus.instr_pc); end
      end
      bus.instr_ready = 1'b1;
      @(negedge clk);
      bus.instr_ready = 1'b0;
      total += 2;
      if (bus.pc !== 8'd12) begin bad++; $display("[TB] FAIL bp_pc_adv got %h want 0c", bus.pc); end
      if (bus.instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_single got valid=%b want 0", bus.instr_valid); end
   endtask

   task automatic test_redirect_fetch();
      bit ok;
      pulse_redirect(8'h10);
      total++;
      if (bus.pc !== 8'h10) begin bad++; $display("[TB] FAIL rf_pc10 got %h want 10", bus.pc); end
      pulse_redirect(8'h5E);
      total += 2;
      if (bus.pc !== 8'h5C) begin bad++; $display("[TB] FAIL rf_pc got %h want 5c", bus.pc); end
      if (bus.instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL rf_valid got %b want 0", bus.instr_valid); end
      wait_valid(ok);
      total += 3;
      if (!ok) begin bad++; $display("[TB] FAIL rf_wait got valid=0 want 1"); end
      if (bus.instr_pc !== 8'h5C) begin bad++; $display("[TB] FAIL rf_instr_pc got %h want 5c", bus.instr_pc); end
      if (bus.instr !== romWord(8'h5C)) begin bad++; $display("[TB] FAIL rf_instr got %h want %h", bus.instr, romWord(8'h5C)); end
   endtask

   task automatic test_redirect_handshake();
      bit ok;
      pulse_redirect(8'h58);
      wait_valid(ok);
      total += 2;
      if (!ok) begin bad++; $display("[TB] FAIL rh_wait got valid=0 want 1"); end
      if (bus.instr_pc !== 8'h58) begin bad++; $display("[TB] FAIL rh_instr_pc got %h want 58", bus.instr_pc); end
      bus.instr_ready = 1'b1;
      pulse_redirect(8'h30);
      bus.instr_ready = 1'b0;
      total += 2;
      if (bus.pc !== 8'h30) begin bad++; $display("[TB] FAIL rh_pc got %h want 30", bus.pc); end
      if (bus.instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL rh_valid got %b want 0", bus.instr_valid); end
      wait_valid(ok);
      total += 2;
      if (!ok) begin bad++; $display("[TB] FAIL rh_wait2 got valid=0 want 1"); end
      if (bus.instr_pc !== 8'h30) begin bad++; $display("[TB] FAIL rh_next_pc got %h want 30", bus.instr_pc); end
   endtask

   task automatic test_halt();
      bit ok;
      pulse_redirect(8'h60);
      wait_valid(ok);
      total += 2;
      if (!ok) begin bad++; $display("[TB] FAIL halt_wait got valid=0 want 1"); end
      if (bus.instr !== 32'h0) begin bad++; $display("[TB] FAIL halt_instr got %h want 0", bus.instr); end
      bus.instr_ready = 1'b1;
      @(negedge clk);
      bus.instr_ready = 1'b0;
      total += 3;
      if (bus.halted !== 1'b1) begin bad++; $display("[TB] FAIL halt_flag got %b want 1", bus.halted); end
      if (bus.pc !== 8'h64) begin bad++; $display("[TB] FAIL halt_pc got %h want 64", bus.pc); end
      if (bus.instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL halt_valid got %b want 0", bus.instr_valid); end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         total += 3;
         if (bus.rom_addr !== 8'h64) begin bad++; $display("[TB] FAIL halt_frozen got %h want 64", bus.rom_addr); end
         if (bus.halted !== 1'b1) begin bad++; $display("[TB] FAIL halt_stay got %b want 1", bus.halted); end
         if (bus.instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL halt_novalid got %b want 0", bus.instr_valid); end
      end
      bus.run = 1'b0;
      pulse_redirect(8'h04);
      total += 2;
      if (bus.halted !== 1'b0) begin bad++; $display("[TB] FAIL unhalt_flag got %b want 0", bus.halted); end
      if (bus.pc !== 8'h04) begin bad++; $display("[TB] FAIL unhalt_pc got %h want 04", bus.pc); end
      wait_valid(ok);
      total += 2;
      if (!ok) begin bad++; $display("[TB] FAIL unhalt_wait got valid=0 want 1"); end
      if (bus.instr_pc !== 8'h04) begin bad++; $display("[TB] FAIL unhalt_instr_pc got %h want 04", bus.instr_pc); end
      bus.instr_ready = 1'b1;
      @(negedge clk);
      bus.instr_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         total += 2;
         if (bus.instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL idle_novalid got %b want 0", bus.instr_valid); end
         if (bus.pc !== 8'h08) begin bad++; $display("[TB] FAIL idle_pc got %h want 08", bus.pc); end
      end
   endtask

   task automatic test_wrap();
      bit ok;
      bus.run = 1'b1;
      pulse_redirect(8'hFD);
      wait_valid(ok);
      total += 3;
      if (!ok) begin bad++; $display("[TB] FAIL wrap_wait got valid=0 want 1"); end
      if (bus.instr_pc !== 8'hFC) begin bad++; $display("[TB] FAIL wrap_instr_pc got %h want fc", bus.instr_pc); end
      if (bus.instr !== romWord(8'hFC)) begin bad++; $display("[TB] FAIL wrap_instr got %h want %h", bus.instr, romWord(8'hFC)); end
      bus.instr_ready = 1'b1;
      @(negedge clk);
      bus.instr_ready = 1'b0;
      total++;
      if (bus.pc !== 8'h00) begin bad++; $display("[TB] FAIL wrap_pc got %h want 00", bus.pc); end
   endtask

   // Transaction-level model: the expected PC moves by +4 per accepted word, jumps on a redirect and freezes on an accepted zero.
   task automatic test_random();
      logic [7:0]  mPc;
      logic        mHalted;
      logic        lastValid, lastReady, lastRedir;
      logic [7:0]  lastTgt;
      logic [31:0] lastInstr;
      int          transfers;
      rst_n = 1'b0;
      bus.run = 1'b0; bus.instr_ready = 1'b0; bus.redirect_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      mPc = 8'd4; mHalted = 1'b0; transfers = 0;
      lastValid = 1'b0; lastReady = 1'b0; lastRedir = 1'b0; lastTgt = 8'h0; lastInstr = 32'h0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(negedge clk);
         if (lastRedir) begin
            mPc = lastTgt & 8'hFC;
            mHalted = 1'b0;
         end else if (lastValid && lastReady) begin
            transfers++;
            mPc = 8'(mPc + 8'd4);
            if (lastInstr == 32'h0) mHalted = 1'b1;
         end
         total += 3;
         if (bus.pc !== mPc) begin bad++; $display("[TB] FAIL rnd_pc cyc=%0d got %h want %h", cyc, bus.pc, mPc); end
         if (bus.rom_addr !== mPc) begin bad++; $display("[TB] FAIL rnd_rom_addr cyc=%0d got %h want %h", cyc, bus.rom_addr, mPc); end
         if (bus.halted !== mHalted) begin bad++; $display("[TB] FAIL rnd_halted cyc=%0d got %b want %b", cyc, bus.halted, mHalted); end
         if (bus.instr_valid) begin
            total += 2;
            if (bus.instr_pc !== mPc) begin bad++; $display("[TB] FAIL rnd_instr_pc cyc=%0d got %h want %h", cyc, bus.instr_pc, mPc); end
            if (bus.instr !== romWord(mPc)) begin bad++; $display("[TB] FAIL rnd_instr cyc=%0d got %h want %h", cyc, bus.instr, romWord(mPc)); end
         end
         if (lastValid && !lastReady && !lastRedir) begin
            total += 2;
            if (bus.instr_valid !== 1'b1) begin bad++; $display("[TB] FAIL rnd_valid_held cyc=%0d got %b want 1", cyc, bus.instr_valid); end
            if (bus.instr !== lastInstr) begin bad++; $display("[TB] FAIL rnd_instr_held cyc=%0d got %h want %h", cyc, bus.instr, lastInstr); end
         end
         bus.run            = ($urandom_range(0, 9) != 0);
         bus.instr_ready    = 1'($urandom_range(0, 1));
         bus.redirect_valid = ($urandom_range(0, 15) == 0);
         bus.redirect_pc    = 8'($urandom);
         lastValid = bus.instr_valid;
         lastInstr = bus.instr;
         lastReady = bus.instr_ready;
         lastRedir = bus.redirect_valid;
         lastTgt   = bus.redirect_pc;
      end
      bus.redirect_valid = 1'b0;
      bus.instr_ready    = 1'b0;
      total++;
      if (transfers < 10) begin bad++; $display("[TB] FAIL rnd_progress got %0d transfers want >=10", transfers); end
   endtask

   task automatic test_async_reset();
      bus.run = 1'b1;
      pulse_redirect(8'h20);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total += 6;
      if (bus.pc !== 8'd4) begin bad++; $display("[TB] FAIL areset_pc got %h want 04", bus.pc); end
      if (bus.rom_addr !== 8'd4) begin bad++; $display("[TB] FAIL areset_rom_addr got %h want 04", bus.rom_addr); end
      if (bus.instr !== 32'h0) begin bad++; $display("[TB] FAIL areset_instr got %h want 0", bus.instr); end
      if (bus.instr_pc !== 8'h0) begin bad++; $display("[TB] FAIL areset_instr_pc got %h want 00", bus.instr_pc); end
      if (bus.instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL areset_valid got %b want 0", bus.instr_valid); end
      if (bus.halted !== 1'b0) begin bad++; $display("[TB] FAIL areset_halted got %b want 0", bus.halted); end
      @(negedge clk);
      bus.run = 1'b0;
      rst_n   = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      load_rom();
      test_reset();
      test_first_fetch();
      test_backpressure();
      test_redirect_fetch();
      test_redirect_handshake();
      test_halt();
      test_wrap();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
